// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave: byte/half/word transfers, fixed wait states, write-to-read forwarding.
// Define AHB_SRAM_ERR_EN to add range/alignment checking with a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int                        AHB_ADDR_WIDTH = 32,
    parameter int                        AHB_DATA_WIDTH = 32,
    parameter int                        MEM_WORDS      = 4096,
    parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter int                        WAIT_STATES    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hsel_i,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
    input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
    input  logic                      hwrite_i,
    input  logic [2:0]                hsize_i,
    input  logic [2:0]                hburst_i,
    input  logic [3:0]                hprot_i,
    input  logic [1:0]                htrans_i,
    input  logic                      hmastlock_i,
    input  logic                      hready_i,
    output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
    output logic                      hreadyout_o,
    output logic                      hresp_o
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
`ifdef AHB_SRAM_ERR_EN
        ,
        S_ERR1,
        S_ERR2
`endif
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            3'd0:    lane_mask = 4'b0001 << lo;
            3'd1:    lane_mask = 4'b0011 << {lo[1], 1'b0};
            default: lane_mask = 4'b1111;
        endcase
    endfunction

`ifdef AHB_SRAM_ERR_EN
    // Base is aligned to the array size, so range check reduces to comparing the upper bits.
    function automatic logic xfer_err(input logic [AHB_ADDR_WIDTH-1:0] addr, input logic [2:0] size);
        logic range_bad;
        range_bad = (addr >> (IDX_W + 2)) != (BASE_ADDR >> (IDX_W + 2));
        xfer_err  = range_bad || (size > 3'd2) || (size == 3'd1 && addr[0]) ||
                    (size == 3'd2 && addr[1:0] != 2'b00);
    endfunction
`endif

    logic [31:0]      mem [MEM_WORDS];

    state_t           state;
    logic [2:0]       wait_cnt;
    logic             hreadyout_q;
    logic [31:0]      hrdata_q;

    logic             vld_p1;
    logic             write_p1;
    logic [IDX_W-1:0] idx_p1;
    logic [3:0]       mask_p1;

    logic             accept;
    logic             err_a;
    logic [IDX_W-1:0] idx_a;
    logic [3:0]       mask_a;
    logic             commit;
    logic [31:0]      rd_merged;
    logic             unused_ok;

    assign accept = hsel_i & hready_i & htrans_i[1] & hreadyout_q;
    assign idx_a  = haddr_i[IDX_W+1:2];
    assign mask_a = lane_mask(hsize_i, haddr_i[1:0]);
`ifdef AHB_SRAM_ERR_EN
    assign err_a  = xfer_err(haddr_i, hsize_i);
`else
    assign err_a  = 1'b0;
`endif
    assign commit = vld_p1 & write_p1 & (state == S_DATA);

    // A write retiring on this edge to the same word overrides the stale array bytes.
    always_comb begin
        rd_merged = mem[idx_a];
        for (int b = 0; b < 4; b++) begin
            if (commit && (idx_p1 == idx_a) && mask_p1[b]) begin
                rd_merged[8*b +: 8] = hwdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_p1[b]) begin
                    mem[idx_p1][8*b +: 8] <= hwdata_i[8*b +: 8];
                end
            end
        end
    end

    // address phase -> data phase
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p1   <= idx_a;
            write_p1 <= hwrite_i;
            mask_p1  <= mask_a;
        end
    end

`ifdef AHB_SRAM_ERR_EN
    logic resp_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 3'd0;
            vld_p1      <= 1'b0;
            hreadyout_q <= 1'b1;
            hrdata_q    <= '0;
`ifdef AHB_SRAM_ERR_EN
            resp_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        state       <= S_DATA;
                        hreadyout_q <= 1'b1;
                    end
                end
`ifdef AHB_SRAM_ERR_EN
                S_ERR1: begin
                    state       <= S_ERR2;
                    hreadyout_q <= 1'b1;
                end
`endif
                default: begin
`ifdef AHB_SRAM_ERR_EN
                    resp_q <= accept & err_a;
`endif
                    if (accept) begin
                        vld_p1   <= ~err_a;
                        hrdata_q <= (hwrite_i || err_a) ? 32'h0 : rd_merged;
`ifdef AHB_SRAM_ERR_EN
                        if (err_a) begin
                            state       <= S_ERR1;
                            hreadyout_q <= 1'b0;
                        end else
`endif
                        if (WAIT_STATES > 0) begin
                            state       <= S_WAIT;
                            wait_cnt    <= 3'(WAIT_STATES);
                            hreadyout_q <= 1'b0;
                        end else begin
                            state       <= S_DATA;
                            hreadyout_q <= 1'b1;
                        end
                    end else begin
                        state       <= S_IDLE;
                        vld_p1      <= 1'b0;
                        hreadyout_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign hrdata_o    = hrdata_q;
    assign hreadyout_o = hreadyout_q;
`ifdef AHB_SRAM_ERR_EN
    assign hresp_o     = resp_q;
`else
    assign hresp_o     = 1'b0;
`endif

    assign unused_ok = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0], haddr_i};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait instance and one three-wait instance on a shared clock.
module tb_ahb_sram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel0, sel3;
    logic [31:0] addr, wdata;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] rdata0, rdata3;
    logic        rdy0, rdy3, resp0, resp3;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n;

    always #5 clk = ~clk;

    ahb_sram_slave #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .hsel_i(sel0), .haddr_i(addr), .hwdata_i(wdata),
        .hwrite_i(wr), .hsize_i(size), .hburst_i(3'b000), .hprot_i(4'b0011),
        .htrans_i(trans), .hmastlock_i(1'b0), .hready_i(rdy0),
        .hrdata_o(rdata0), .hreadyout_o(rdy0), .hresp_o(resp0)
    );

    ahb_sram_slave #(.WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .hsel_i(sel3), .haddr_i(addr), .hwdata_i(wdata),
        .hwrite_i(wr), .hsize_i(size), .hburst_i(3'b000), .hprot_i(4'b0011),
        .htrans_i(trans), .hmastlock_i(1'b0), .hready_i(rdy3),
        .hrdata_o(rdata3), .hreadyout_o(rdy3), .hresp_o(resp3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr_ph(input logic s0, input logic s3, input logic w,
                           input logic [2:0] sz, input logic [31:0] a);
        sel0  = s0;
        sel3  = s3;
        wr    = w;
        size  = sz;
        addr  = a;
        trans = 2'b10;
    endtask

    task automatic idle_ph();
        sel0  = 1'b0;
        sel3  = 1'b0;
        trans = 2'b00;
    endtask

    task automatic wait_ready3(output int cnt);
        cnt = 0;
        while (rdy3 !== 1'b1 && cnt < 20) begin
            cnt++;
            step();
        end
    endtask

    // Word transfer on the wait-state instance; returns in its data (ready) cycle.
    task automatic xfer3(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
        int cnt;
        addr_ph(1'b0, 1'b1, w, 3'd2, a);
        step();
        idle_ph();
        wdata = d;
        wait_ready3(cnt);
        check({tag, "_waits"}, 32'(cnt), 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_ph();
        addr = '0; wdata = '0; wr = 1'b0; size = 3'd2;
        step(); step();
        rst = 1'b0;
        check("rst_rdy0", {31'b0, rdy0}, 32'd1);
        check("rst_resp0", {31'b0, resp0}, 32'd0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdy3", {31'b0, rdy3}, 32'd1);

        // Write then back-to-back read of the same word
        addr_ph(1'b1, 1'b0, 1'b1, 3'd2, 32'h10);
        step();
        check("t1_wr_rdy", {31'b0, rdy0}, 32'd1);
        wdata = 32'hDEAD_BEEF;
        addr_ph(1'b1, 1'b0, 1'b0, 3'd2, 32'h10);
        step();
        check("t1_rd_data", rdata0, 32'hDEAD_BEEF);
        check("t1_rd_rdy", {31'b0, rdy0}, 32'd1);
        check("t1_rd_resp", {31'b0, resp0}, 32'd0);
        idle_ph();
        step();
        check("t1_hold", rdata0, 32'hDEAD_BEEF);

        // Preload, byte write, forwarded read, halfword write, forwarded read
        addr_ph(1'b1, 1'b0, 1'b1, 3'd2, 32'h20);
        step();
        check("t2_wr_zero", rdata0, 32'h0);
        wdata = 32'h1122_3344;
        addr_ph(1'b1, 1'b0, 1'b1, 3'd0, 32'h21);
        step();
        wdata = 32'hAAAA_AAAA;
        addr_ph(1'b1, 1'b0, 1'b0, 3'd2, 32'h20);
        step();
        check("t2_fwd_byte", rdata0, 32'h1122_AA44);
        addr_ph(1'b1, 1'b0, 1'b1, 3'd1, 32'h22);
        step();
        wdata = 32'h5566_7788;
        addr_ph(1'b1, 1'b0, 1'b0, 3'd2, 32'h20);
        step();
        check("t2_fwd_half", rdata0, 32'h5566_AA44);
        idle_ph();
        step();
        addr_ph(1'b1, 1'b0, 1'b0, 3'd2, 32'h20);
        step();
        idle_ph();
        check("t2_mem", rdata0, 32'h5566_AA44);
        step();

        // Preload word 0 for the range tests
        addr_ph(1'b1, 1'b0, 1'b1, 3'd2, 32'h0);
        step();
        wdata = 32'h1234_5678;
        idle_ph();
        step();
`ifdef AHB_SRAM_ERR_EN
        addr_ph(1'b1, 1'b0, 1'b1, 3'd2, 32'h4000);
        step();
        idle_ph();
        wdata = 32'hFFFF_FFFF;
        check("e1_resp_c1", {31'b0, resp0}, 32'd1);
        check("e1_rdy_c1", {31'b0, rdy0}, 32'd0);
        step();
        check("e1_resp_c2", {31'b0, resp0}, 32'd1);
        check("e1_rdy_c2", {31'b0, rdy0}, 32'd1);
        step();
        check("e1_resp_end", {31'b0, resp0}, 32'd0);
        addr_ph(1'b1, 1'b0, 1'b1, 3'd1, 32'h3);
        step();
        idle_ph();
        check("e2_resp_c1", {31'b0, resp0}, 32'd1);
        check("e2_rdy_c1", {31'b0, rdy0}, 32'd0);
        step();
        check("e2_resp_c2", {31'b0, resp0}, 32'd1);
        check("e2_rdy_c2", {31'b0, rdy0}, 32'd1);
        step();
        addr_ph(1'b1, 1'b0, 1'b0, 3'd2, 32'h0);
        step();
        idle_ph();
        check("e_mem_unchanged", rdata0, 32'h1234_5678);
        check("e_rd_resp", {31'b0, resp0}, 32'd0);
        step();
`else
        addr_ph(1'b1, 1'b0, 1'b1, 3'd0, 32'h4000);
        step();
        wdata = 32'h5555_5555;
        check("w_wr_resp", {31'b0, resp0}, 32'd0);
        check("w_wr_rdy", {31'b0, rdy0}, 32'd1);
        addr_ph(1'b1, 1'b0, 1'b0, 3'd2, 32'h0);
        step();
        check("w_fwd", rdata0, 32'h1234_5655);
        check("w_resp", {31'b0, resp0}, 32'd0);
        addr_ph(1'b1, 1'b0, 1'b0, 3'd2, 32'h0);
        step();
        idle_ph();
        check("w_mem", rdata0, 32'h1234_5655);
        step();
`endif

        // Wait-state instance: write then read word 0
        xfer3(1'b1, 32'h0, 32'hCAFE_F00D, "ws_wr0");
        xfer3(1'b0, 32'h0, 32'h0, "ws_rd0");
        check("ws_rd0_data", rdata3, 32'hCAFE_F00D);
        check("ws_rd0_resp", {31'b0, resp3}, 32'd0);
        idle_ph();
        step();
        check("ws_idle_rdy", {31'b0, rdy3}, 32'd1);

        // Reset during the wait of a write aborts it
        xfer3(1'b1, 32'h8, 32'h0102_0304, "ws_pre8");
        addr_ph(1'b0, 1'b1, 1'b1, 3'd2, 32'h8);
        step();
        idle_ph();
        wdata = 32'hFFFF_FFFF;
        check("rst_in_wait", {31'b0, rdy3}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_rdy", {31'b0, rdy3}, 32'd1);
        check("mid_rst_rdata", rdata3, 32'h0);
        check("mid_rst_resp", {31'b0, resp3}, 32'd0);
        step();
        xfer3(1'b0, 32'h8, 32'h0, "ws_rd8");
        check("ws_rd8_old", rdata3, 32'h0102_0304);
        idle_ph();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite single-port SRAM slave that consumes the instruction or data master bus produced by the core's AHB wrapper. One instance is placed downstream of each master port in the simulation top and acts as the program/data memory. It supports byte, halfword and word transfers and a fixed number of wait states. Out-of-range and illegal transfers optionally return a two-cycle ERROR response.

## Interface
Parameters:
- AHB_ADDR_WIDTH, 32, address bus width
- AHB_DATA_WIDTH, 32, data bus width; only 32 is supported
- MEM_WORDS, 4096, depth in 32-bit words; must be a power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_WORDS*4
- WAIT_STATES, 0, data-phase wait cycles per transfer, 0..7

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- hsel_i  in  1  slave select
- haddr_i  in  AHB_ADDR_WIDTH  byte address
- hwdata_i  in  AHB_DATA_WIDTH  write data, valid in the data phase
- hwrite_i  in  1  1 = write
- hsize_i  in  3  0 = byte, 1 = half, 2 = word
- hburst_i  in  3  ignored; every beat is decoded independently
- hprot_i  in  4  ignored
- htrans_i  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- hmastlock_i  in  1  ignored
- hready_i  in  1  bus ready; qualifies the address phase
- hrdata_o  out  AHB_DATA_WIDTH  read data
- hreadyout_o  out  1  slave ready
- hresp_o  out  1  0 OKAY, 1 ERROR

## Operation
- **Accept condition:** hsel_i & hready_i & htrans_i[1] at a rising edge.
  - On accept, register the word index, hwrite_i, the byte mask and the error flag.
  - IDLE/BUSY transfers and unselected cycles get a zero-wait OKAY.
- **Byte mask from hsize_i/haddr_i[1:0]:**
  - byte: 1<<addr[1:0]
  - half: 4'b0011 << (2*addr[1])
  - word: 4'b1111
- **Error flag:** set for any of the following:
  - address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4)
  - hsize_i>2
  - half with addr[0]=1
  - word with addr[1:0]≠0
- **States:**
  - IDLE: hreadyout_o=1. Accept with no error goes to WAIT if WAIT_STATES>0, else DATA. Accept with error goes to ERR1.
  - WAIT: hreadyout_o=0, hresp_o=0. Counter is loaded with WAIT_STATES on accept and decrements each cycle. At 1 → DATA.
  - DATA: hreadyout_o=1, hresp_o=0. Completes the transfer. A new accept in this cycle pipelines directly to WAIT/DATA/ERR1; otherwise → IDLE.
  - ERR1: hreadyout_o=0, hresp_o=1 → ERR2.
  - ERR2: hreadyout_o=1, hresp_o=1. A new accept is handled as in DATA.
- **Write:**
  - Bytes of hwdata_i selected by the mask commit at the edge ending DATA.
  - Errored writes never commit.
- **Read:**
  - The array is read at the accept edge; data is registered and held on hrdata_o until the next read completes.
  - **Forwarding:** a write committing on the same edge a read to the same word is accepted has its masked bytes merged into that read's data. Read-after-write therefore returns new data with zero wait states.
- hrdata_o is 0 for writes and errored reads.

## Timing
- Address phase in cycle A; data phase starts A+1.
- Read/write OKAY latency: hreadyout_o high in cycle A+1+WAIT_STATES.
- ERROR: hresp_o=1 in A+1 and A+2; hreadyout_o=0 in A+1, 1 in A+2.
- Back-to-back NONSEQ/SEQ at WAIT_STATES=0: one transfer per cycle.
- **Reset values:**
  - hreadyout_o=1, hresp_o=0, hrdata_o=0
  - state IDLE, wait counter 0, forwarding register invalid
- Memory contents are not reset.
- Reset asserted mid-transfer aborts it; a pending write is not committed.
- Addresses wrap modulo MEM_WORDS only when error checking is compiled out.

## Configuration
- Macro: AHB_SRAM_ERR_EN.
- **Defined:**
  - error flag logic and states ERR1/ERR2 are present
  - behaviour as above
- **Undefined:**
  - hresp_o is tied 0 and no error states exist
  - word index = haddr_i[log2(MEM_WORDS)+1:2], wrapping modulo MEM_WORDS
  - hsize_i>2 is treated as word
  - misaligned addresses use the mask of the aligned lane

## Test plan
- WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back → hrdata_o=0xDEADBEEF in the cycle after the read address phase, hreadyout_o never low.
- Preload 0x11223344 at 0x20; byte write 0xAA to 0x21 with the read of 0x20 in its data phase → read returns 0x1122AA44 (forwarding).
- WAIT_STATES=3: read 0x0 → hreadyout_o low exactly 3 cycles, then high with data.
- AHB_SRAM_ERR_EN, MEM_WORDS=4096: write to 0x4000 → hresp_o=1 for 2 cycles, hreadyout_o 0 then 1, memory unchanged. Repeat for a halfword write at 0x3 → same ERROR response.
- Without AHB_SRAM_ERR_EN: write 0x55 to 0x4000, then read 0x0 → byte 0 = 0x55, hresp_o=0.
- Assert rst during the WAIT of a write to 0x8 → after reset hreadyout_o=1, hrdata_o=0; a subsequent read of 0x8 returns the old contents.
